uaz_data_bus_mem_io: RTL

Data-side memory and memory-mapped peripheral block for the 8-bit MicroUAZ core. It sits directly downstream of the core's data bus: it consumes the core's address, write-data and RW strobe, and returns load data on the core's data-input bus. It holds 240 bytes of RAM plus a small I/O window containing a GPIO output port, a synchronised GPIO input port, and an 8-bit prescaled timer with overflow interrupt.

---
 rtl/uaz_data_bus_mem_io.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/uaz_data_bus_mem_io.sv
// ---------------------------------------------------------------------------
// uaz_data_bus_mem_io
//
// Data-side memory and memory-mapped peripherals for the 8-bit MicroUAZ core.
// Provides 240 bytes of RAM below IO_BASE, plus an I/O window holding a GPIO
// output port, a synchronised GPIO input port, and an 8-bit prescaled timer
// with an overflow interrupt.
//
// I/O window (offsets from IO_BASE):
//   +0 GPIO_OUT  R/W   drives o_Gpio
//   +1 GPIO_IN   R     last synchroniser stage
//   +2 TMR_CNT   R/W   a write loads the counter
//   +3 TMR_RLD   R/W   reload value used when AUTORELOAD=1
//   +4 TMR_CTRL  R/W   {OVF(w1c), IRQ_EN, 00, PSC[1:0], AUTORELOAD, EN}
//   +5..         reads 0x00, writes ignored
//
// Ports:
//   Clk                single clock, rising-edge
//   Rst                synchronous active-high reset
//   i_Addres_Data_Bus  data address from the core
//   i_DataOut_Bus      store data from the core
//   RW                 1 = store this cycle, 0 = load
//   o_Dato_Bus         load data, combinational from the address
//   i_Gpio             asynchronous external inputs
//   o_Gpio             registered GPIO output port
//   o_Irq              timer interrupt (OVF & IRQ_EN)
// ---------------------------------------------------------------------------
module uaz_data_bus_mem_io #(
    parameter logic [7:0] IO_BASE     = 8'hF0,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [7:0] i_Addres_Data_Bus,
    input  logic [7:0] i_DataOut_Bus,
    input  logic       RW,
    output logic [7:0] o_Dato_Bus,
    input  logic [7:0] i_Gpio,
    output logic [7:0] o_Gpio,
    output logic       o_Irq
);

    localparam int         RAM_DEPTH     = int'(IO_BASE);
    localparam logic [7:0] ADDR_GPIO_OUT = IO_BASE;
    localparam logic [7:0] ADDR_GPIO_IN  = IO_BASE + 8'd1;
    localparam logic [7:0] ADDR_TMR_CNT  = IO_BASE + 8'd2;
    localparam logic [7:0] ADDR_TMR_RLD  = IO_BASE + 8'd3;
    localparam logic [7:0] ADDR_TMR_CTRL = IO_BASE + 8'd4;

    typedef struct packed {
        logic       ovf;
        logic       irq_en;
        logic [1:0] psc;
        logic       autoreload;
        logic       en;
    } tmr_ctrl_t;

    logic [7:0] ram [RAM_DEPTH];
    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] gpio_out;
    logic [7:0] tmr_cnt;
    logic [7:0] tmr_rld;
    tmr_ctrl_t  tmr_ctrl;
    logic [5:0] prescaler;

    logic       is_ram;
    logic       wr_gpio, wr_cnt, wr_rld, wr_ctrl;
    logic       psc_match;
    logic       tick;
    logic       ovf_event;

    assign is_ram  = i_Addres_Data_Bus < IO_BASE;
    assign wr_gpio = RW && (i_Addres_Data_Bus == ADDR_GPIO_OUT);
    assign wr_cnt  = RW && (i_Addres_Data_Bus == ADDR_TMR_CNT);
    assign wr_rld  = RW && (i_Addres_Data_Bus == ADDR_TMR_RLD);
    assign wr_ctrl = RW && (i_Addres_Data_Bus == ADDR_TMR_CTRL);

    // Tick when the selected low prescaler bits are all ones.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        psc_match = 1'b0;
        unique case (tmr_ctrl.psc)
            2'd0: psc_match = 1'b1;
            2'd1: psc_match = &prescaler[1:0];
            2'd2: psc_match = &prescaler[3:0];
            2'd3: psc_match = &prescaler[5:0];
        endcase
    end

    assign tick = tmr_ctrl.en && psc_match;
    // A CPU write to TMR_CNT swallows a coincident tick, overflow included.
    assign ovf_event = tick && (tmr_cnt == 8'hFF) && !wr_cnt;

    // RAM. Reset suppresses the write but never clears the contents.
    // NOTE: memory arrays are deliberately left out of reset; clearing them
    // would need a per-word reset path the storage does not have.
    always_ff @(posedge Clk) begin
        if (!Rst && RW && is_ram) begin
            ram[i_Addres_Data_Bus] <= i_DataOut_Bus;
        end
    end

    // GPIO input synchroniser chain.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, which is what makes this a shift chain.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= i_Gpio;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            gpio_out <= 8'h00;
        end else if (wr_gpio) begin
            gpio_out <= i_DataOut_Bus;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            tmr_cnt   <= 8'h00;
            tmr_rld   <= 8'hFF;
            tmr_ctrl  <= '0;
            prescaler <= 6'd0;
        end else begin
            if (wr_cnt) begin
                tmr_cnt <= i_DataOut_Bus;
            end else if (tick) begin
                if (tmr_cnt == 8'hFF) begin
                    tmr_cnt <= tmr_ctrl.autoreload ? tmr_rld : 8'h00;
                end else begin
                    tmr_cnt <= tmr_cnt + 8'd1;
                end
            end

            if (wr_rld) begin
                tmr_rld <= i_DataOut_Bus;
            end

            if (wr_ctrl) begin
                tmr_ctrl.irq_en     <= i_DataOut_Bus[6];
                tmr_ctrl.psc        <= i_DataOut_Bus[3:2];
                tmr_ctrl.autoreload <= i_DataOut_Bus[1];
                tmr_ctrl.en         <= i_DataOut_Bus[0];
            end

            // Set outranks a simultaneous write-1-to-clear.
            if (ovf_event) begin
                tmr_ctrl.ovf <= 1'b1;
            end else if (wr_ctrl && i_DataOut_Bus[7]) begin
                tmr_ctrl.ovf <= 1'b0;
            end

            // Restarting on a control write aligns the first tick to it.
            if (wr_ctrl || !tmr_ctrl.en) begin
                prescaler <= 6'd0;
            end else begin
                prescaler <= prescaler + 6'd1;
            end
        end
    end

    always_comb begin
        o_Dato_Bus = 8'h00;
        if (is_ram) begin
            o_Dato_Bus = ram[i_Addres_Data_Bus];
        end else begin
            case (i_Addres_Data_Bus)
                ADDR_GPIO_OUT: o_Dato_Bus = gpio_out;
                ADDR_GPIO_IN:  o_Dato_Bus = sync_q[SYNC_STAGES-1];
                ADDR_TMR_CNT:  o_Dato_Bus = tmr_cnt;
                ADDR_TMR_RLD:  o_Dato_Bus = tmr_rld;
                ADDR_TMR_CTRL: o_Dato_Bus = {tmr_ctrl.ovf, tmr_ctrl.irq_en, 2'b00,
                                             tmr_ctrl.psc, tmr_ctrl.autoreload,
                                             tmr_ctrl.en};
                default:       o_Dato_Bus = 8'h00;
            endcase
        end
    end

    assign o_Gpio = gpio_out;
    assign o_Irq  = tmr_ctrl.ovf & tmr_ctrl.irq_en;

endmodule
